// File: rtl/ud_dir_ctrl.sv
// ud_dir_ctrl: direction/clear controller for a 4-bit up/down counter.
// Two raw buttons (direction toggle, clear) are synchronized, optionally
// debounced, and turned into press events that drive a small UP/DOWN/CLR FSM.
// In auto mode the FSM ping-pongs between LO and HI using the counter feedback.
// Build option: define UD_CTRL_DEBOUNCE_EN to include the per-button debouncer;
// without it the synchronized level is used directly and DB_CYCLES is unused.
module ud_dir_ctrl #(
   parameter int         DB_CYCLES = 4,
   parameter logic [3:0] HI        = 4'd14,
   parameter logic [3:0] LO        = 4'd1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_dir,
   input  logic       btn_clr,
   input  logic       mode,
   input  logic [3:0] count,
   output logic       ud,
   output logic       cnt_rst,
   output logic       dir_chg
);

   typedef enum logic [1:0] {ST_UP, ST_DOWN, ST_CLR} state_e;

   // Button index 0 = direction, 1 = clear.
   localparam int BTN_DIR = 0;
   localparam int BTN_CLR = 1;

   // A debounce threshold outside 1..15 does not fit the 4-bit counter.
   if (DB_CYCLES < 1 || DB_CYCLES > 15) begin : g_db_range_err
      $error("ud_dir_ctrl: DB_CYCLES must be in 1..15");
   end

   logic [1:0] btn_raw;
   logic [1:0] s1_q, s2_q;
   logic [1:0] lvl;
   logic [1:0] prev_q, prev_d;
   logic [1:0] press;

   state_e     state_q, state_d;
   logic       clr_cnt_q, clr_cnt_d;
   logic       ud_q, ud_d;
   logic       cnt_rst_q, cnt_rst_d;
   logic       dir_chg_q, dir_chg_d;

   assign btn_raw = {btn_clr, btn_dir};

   // Two-flop synchronizer for both raw buttons.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= btn_raw;
         s2_q <= s1_q;
      end
   end

`ifdef UD_CTRL_DEBOUNCE_EN
   logic [1:0][3:0] db_cnt_q, db_cnt_d;
   logic [1:0]      db_q, db_d;

   // Count consecutive cycles the synchronized level disagrees with the
   // debounced level; adopt the new level on the DB_CYCLES-th one.
   always_comb begin
      db_cnt_d = db_cnt_q;
      db_d     = db_q;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] != db_q[i]) begin
            if (db_cnt_q[i] == 4'(DB_CYCLES - 1)) begin
               db_d[i]     = s2_q[i];
               db_cnt_d[i] = '0;
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 4'd1;
            end
         end else begin
            db_cnt_d[i] = '0;
         end
      end
   end

   // Debouncer state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt_q <= '0;
         db_q     <= '0;
      end else begin
         db_cnt_q <= db_cnt_d;
         db_q     <= db_d;
      end
   end

   assign lvl = db_q;
`else
   assign lvl = s2_q;
`endif

   // Press event is the rising edge of the (debounced) level only.
   assign prev_d = lvl;
   assign press  = lvl & ~prev_q;

   // Previous-level register for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= '0;
      else     prev_q <= prev_d;
   end

   // Next state: clear beats everything, then auto limit / manual toggle.
   // Outputs are derived from the next state so they register with it.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (press[BTN_CLR]) begin
         state_d   = ST_CLR;
         clr_cnt_d = 1'b0;
      end else begin
         case (state_q)
            ST_UP:   if (mode ? (count >= HI) : press[BTN_DIR]) state_d = ST_DOWN;
            ST_DOWN: if (mode ? (count <= LO) : press[BTN_DIR]) state_d = ST_UP;
            ST_CLR: begin
               if (clr_cnt_q) begin
                  state_d   = ST_UP;
                  clr_cnt_d = 1'b0;
               end else begin
                  clr_cnt_d = 1'b1;
               end
            end
            default: state_d = ST_UP;
         endcase
      end
      ud_d      = (state_d != ST_DOWN);
      cnt_rst_d = (state_d == ST_CLR);
      dir_chg_d = (ud_d != ud_q);
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_UP;
         clr_cnt_q <= 1'b0;
         ud_q      <= 1'b1;
         cnt_rst_q <= 1'b0;
         dir_chg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ud_q      <= ud_d;
         cnt_rst_q <= cnt_rst_d;
         dir_chg_q <= dir_chg_d;
      end
   end

   assign ud      = ud_q;
   assign cnt_rst = cnt_rst_q;
   assign dir_chg = dir_chg_q;

endmodule

// File: doc/ud_dir_ctrl.md
UD_DIR_CTRL -- requirements
Module: ud_dir_ctrl

Interface
REQ-001 Parameter: DB_CYCLES, default 4, consecutive stable cycles before a debounced button level changes (range 1..15).
REQ-002 Parameter: HI, default 4'd14, upper turn-around limit in auto mode.
REQ-003 Parameter: LO, default 4'd1, lower turn-around limit in auto mode (LO < HI).
REQ-004 Ports: clk  in  1  single clock, all state on rising edge.
REQ-005 Ports: rst  in  1  reset, asynchronous, active-high.
REQ-006 Ports: btn_dir  in  1  raw asynchronous direction-toggle button.
REQ-007 Ports: btn_clr  in  1  raw asynchronous clear button.
REQ-008 Ports: mode  in  1  0 = manual, 1 = auto ping-pong; synchronous to clk.
REQ-009 Ports: count  in  4  feedback from the downstream up/down counter.
REQ-010 Ports: ud  out  1  direction to counter, 1 = up, 0 = down; registered.
REQ-011 Ports: cnt_rst  out  1  synchronous clear request to counter; registered.
REQ-012 Ports: dir_chg  out  1  one-cycle pulse, high in the cycle ud takes a new value.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer (s1, s2) before any other logic.
REQ-014 Debouncer SHALL count consecutive edges where s2 != debounced level; counter clears when equal; debounced level takes s2 on the DB_CYCLES-th such edge.
REQ-015 Button press event SHALL be the rising edge of the debounced level (level & ~previous level); falling edges produce no event.
REQ-016 FSM states SHALL be UP (ud=1), DOWN (ud=0), CLR (ud=1, cnt_rst=1).
REQ-017 CLR SHALL hold cnt_rst=1 for exactly 2 cycles, then go to UP.
REQ-018 Clear event in any state SHALL enter CLR; clear event while in CLR restarts the 2-cycle hold.
REQ-019 Manual mode: direction event SHALL toggle UP<->DOWN on the next edge.
REQ-020 Auto mode: UP with count >= HI SHALL go to DOWN; DOWN with count <= LO SHALL go to UP; direction events ignored.
REQ-021 Priority per cycle: clear event > auto limit / manual toggle > hold.
REQ-022 Mode change SHALL take effect on the first edge it is sampled; no state is reset by it.
REQ-023 dir_chg SHALL be registered so that it is 1 exactly in cycles where ud differs from its previous-cycle value.
REQ-024 Latency with debounce: raw button rise before edge E0 -> ud changes at edge E(DB_CYCLES+2), i.e. the 7th edge for DB_CYCLES=4.

Reset
REQ-025 rst=1 SHALL immediately force: state UP, ud=1, cnt_rst=0, dir_chg=0, synchronizers/debounced levels/previous levels 0, debounce and CLR counters 0.
REQ-026 rst asserted mid-CLR SHALL drop cnt_rst to 0 without waiting for clk.
REQ-027 A button held high through reset release SHALL produce one press event after debounce.

Configuration
REQ-028 Macro UD_CTRL_DEBOUNCE_EN defined: debouncer per REQ-014 is present.
REQ-029 Macro UD_CTRL_DEBOUNCE_EN undefined: debounced level = s2 directly, DB_CYCLES unused; raw rise before E0 -> ud changes at E2.

Verification (DB_CYCLES=4, HI=14, LO=1, macro defined unless noted)
REQ-030 Assert rst for 3 cycles, buttons 0 -> ud=1, cnt_rst=0, dir_chg=0 throughout and after release.
REQ-031 mode=0, btn_dir 0->1 held 10 cycles before E0 -> ud 1->0 at E6 with dir_chg=1 for that cycle only; second press -> ud back to 1.
REQ-032 mode=0, btn_dir high 3 cycles then low -> ud stays 1, dir_chg never asserts.
REQ-033 mode=1, count ramps 0..14 -> ud=0 on edge after count=14 seen; count ramps down to 1 -> ud=1 on edge after; btn_dir presses meanwhile ignored.
REQ-034 In DOWN, btn_clr press -> cnt_rst=1 for exactly 2 cycles, then ud=1; dir_chg pulses in the cycle ud goes 0->1 (CLR entry).
REQ-035 rst asserted during cnt_rst=1 -> cnt_rst=0 same timestep; macro undefined rerun of REQ-031 -> ud changes at E2.
